// File: rtl/seg_demux_if.sv
// rtl/seg_demux_if.sv - scanned 7-segment bus and rebuilt-frame signals
interface seg_demux_if;
  logic [7:0]      seg;
  logic [3:0]      dig;
  logic [3:0][7:0] seg_out;
  logic [3:0][3:0] hex_out;
  logic [3:0]      hex_ok;
  logic            frame_valid;
  logic            scan_err;

  modport master (
    output seg, dig,
    input  seg_out, hex_out, hex_ok, frame_valid, scan_err
  );

  modport slave (
    input  seg, dig,
    output seg_out, hex_out, hex_ok, frame_valid, scan_err
  );
endinterface

// File: rtl/seg_demux.sv
// rtl/seg_demux.sv - receive end of a 4-digit scanned 7-segment display bus
module seg_demux #(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int IDLE_LIMIT     = 16
) (
  input  logic      clk,
  input  logic      nrst,
  seg_demux_if.slave bus
);

  typedef enum logic {HUNT = 1'b0, TRACK = 1'b1} state_t;

  localparam logic [7:0] IDLE_LIM = 8'(IDLE_LIMIT);

  state_t          state_q, state_n;
  logic [1:0]      exp_q, exp_n;
  logic [7:0]      idle_q, idle_n, idle_inc;
  logic [3:0][7:0] shadow_q, shadow_n;
  logic            publish, err_n;

  logic [3:0][7:0] seg_out_q;
  logic [3:0][3:0] hex_out_q;
  logic [3:0]      hex_ok_q;
  logic            frame_valid_q, scan_err_q;

  logic [2:0]      low_cnt;
  logic            is_valid, is_blank, is_dig0;
  logic [1:0]      idx;

  // Maps a raw segment byte to {match, hex value}; dp never takes part.
  function automatic logic [4:0] decode(input logic [7:0] s);
    logic [6:0] lit;
    lit = SEG_ACTIVE_LOW ? ~s[6:0] : s[6:0];
    case (lit)
      7'h3F: return 5'h10;
      7'h06: return 5'h11;
      7'h5B: return 5'h12;
      7'h4F: return 5'h13;
      7'h66: return 5'h14;
      7'h6D: return 5'h15;
      7'h7D: return 5'h16;
      7'h07: return 5'h17;
      7'h7F: return 5'h18;
      7'h6F: return 5'h19;
      7'h77: return 5'h1A;
      7'h7C: return 5'h1B;
      7'h39: return 5'h1C;
      7'h5E: return 5'h1D;
      7'h79: return 5'h1E;
      7'h71: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  assign low_cnt  = {2'b00, ~bus.dig[0]} + {2'b00, ~bus.dig[1]} +
                    {2'b00, ~bus.dig[2]} + {2'b00, ~bus.dig[3]};
  assign is_valid = (low_cnt == 3'd1);
  assign is_blank = (bus.dig == 4'b1111);
  assign is_dig0  = (bus.dig == 4'b1110);
  assign idle_inc = (idle_q == 8'hFF) ? idle_q : idle_q + 8'd1;

  // Index of the single low strobe bit; only meaningful when is_valid.
  always_comb begin
    idx = 2'd0;
    case (bus.dig)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  // Scan tracker: next state, expected digit, idle count, shadow bytes, pulses.
  always_comb begin
    state_n  = state_q;
    exp_n    = exp_q;
    idle_n   = idle_q;
    shadow_n = shadow_q;
    publish  = 1'b0;
    err_n    = 1'b0;
    case (state_q)
      HUNT: begin
        if (is_dig0) begin
          shadow_n[0] = bus.seg;
          exp_n       = 2'd1;
          idle_n      = 8'd0;
          state_n     = TRACK;
        end
      end
      TRACK: begin
        if (is_valid && idx == exp_q) begin
          shadow_n[idx] = bus.seg;
          idle_n        = 8'd0;
          exp_n         = exp_q + 2'd1;
          publish       = (idx == 2'd3);
        end else if (is_valid && exp_q != 2'd0 && idx == exp_q - 2'd1) begin
          // Display held on the last captured digit: keep the newest byte.
          shadow_n[idx] = bus.seg;
          idle_n        = 8'd0;
        end else if (is_blank) begin
          if (idle_inc >= IDLE_LIM) begin
            state_n  = HUNT;
            exp_n    = 2'd0;
            idle_n   = 8'd0;
            shadow_n = '0;
          end else begin
            idle_n = idle_inc;
          end
        end else begin
          // Out-of-order or illegal strobe; a digit-0 strobe resyncs at once.
          err_n    = 1'b1;
          shadow_n = '0;
          idle_n   = 8'd0;
          if (is_dig0) begin
            shadow_n[0] = bus.seg;
            exp_n       = 2'd1;
          end else begin
            state_n = HUNT;
            exp_n   = 2'd0;
          end
        end
      end
      default: begin
        state_n  = HUNT;
        exp_n    = 2'd0;
        idle_n   = 8'd0;
        shadow_n = '0;
      end
    endcase
  end

  // Tracker state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= HUNT;
      exp_q    <= 2'd0;
      idle_q   <= 8'd0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_n;
      exp_q    <= exp_n;
      idle_q   <= idle_n;
      shadow_q <= shadow_n;
    end
  end

  // Publishes the completed frame and its decode together with the pulses.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      seg_out_q     <= '0;
      hex_out_q     <= '0;
      hex_ok_q      <= 4'b0000;
      frame_valid_q <= 1'b0;
      scan_err_q    <= 1'b0;
    end else begin
      frame_valid_q <= publish;
      scan_err_q    <= err_n;
      if (publish) begin
        seg_out_q <= shadow_n;
        for (int n = 0; n < 4; n++) begin
          hex_ok_q[n]  <= decode(shadow_n[n])[4];
          hex_out_q[n] <= decode(shadow_n[n])[3:0];
        end
      end
    end
  end

  assign bus.seg_out     = seg_out_q;
  assign bus.hex_out     = hex_out_q;
  assign bus.hex_ok      = hex_ok_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.scan_err    = scan_err_q;

endmodule
